// File: rtl/map_state_reader.sv
// Snapshots the live 4510 mapper state and plays it back as the four MAP
// operand bytes (A, X, Y, Z), advancing one byte per cycle that ready is high.
module map_state_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] map_offset0_i,
    input  logic [11:0] map_offset1_i,
    input  logic [7:0]  map_enable_i,
    output logic [7:0]  data_o,
    output logic        valid,
    output logic        busy,
    output logic [1:0]  byte_sel,
    output logic        last,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_X = 3'd2,
        SEND_Y = 3'd3,
        SEND_Z = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] snapOff0_q, snapOff1_q;
    logic [7:0]  snapEn_q;
    logic        done_q, done_d;
    logic        capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            snapOff0_q <= 12'h000;
            snapOff1_q <= 12'h000;
            snapEn_q   <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (capture) begin
                snapOff0_q <= map_offset0_i;
                snapOff1_q <= map_offset1_i;
                snapEn_q   <= map_enable_i;
            end
        end
    end

    // Abort takes priority over ready in every SEND state, so it never yields done.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && ready && !abort) begin
                    state_d = SEND_A;
                    capture = 1'b1;
                end
            end
            SEND_A: begin
                if (abort)      state_d = IDLE;
                else if (ready) state_d = SEND_X;
            end
            SEND_X: begin
                if (abort)      state_d = IDLE;
                else if (ready) state_d = SEND_Y;
            end
            SEND_Y: begin
                if (abort)      state_d = IDLE;
                else if (ready) state_d = SEND_Z;
            end
            SEND_Z: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_o   = 8'h00;
        byte_sel = 2'd0;
        last     = 1'b0;
        valid    = (state_q != IDLE);
        busy     = (state_q != IDLE);
        done     = done_q;
        case (state_q)
            SEND_A: begin
                data_o   = snapOff0_q[7:0];
                byte_sel = 2'd0;
            end
            SEND_X: begin
                data_o   = {snapEn_q[3:0], snapOff0_q[11:8]};
                byte_sel = 2'd1;
            end
            SEND_Y: begin
                data_o   = snapOff1_q[7:0];
                byte_sel = 2'd2;
            end
            SEND_Z: begin
                data_o   = {snapEn_q[7:4], snapOff1_q[11:8]};
                byte_sel = 2'd3;
                last     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_map_state_reader.sv
// Directed bench for map_state_reader: a playback-position model checked every
// cycle, plus literal byte expectations taken from the mapper encoding.
module tb_map_state_reader;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        start;
    logic        abort;
    logic [11:0] mapOffset0;
    logic [11:0] mapOffset1;
    logic [7:0]  mapEnable;
    logic [7:0]  dataOut;
    logic        valid;
    logic        busy;
    logic [1:0]  byteSel;
    logic        last;
    logic        done;

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;

    map_state_reader dut (
        .clk           (clk),
        .reset         (reset),
        .ready         (ready),
        .start         (start),
        .abort         (abort),
        .map_offset0_i (mapOffset0),
        .map_offset1_i (mapOffset1),
        .map_enable_i  (mapEnable),
        .data_o        (dataOut),
        .valid         (valid),
        .busy          (busy),
        .byte_sel      (byteSel),
        .last          (last),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: playback position (-1 idle, 0..3 = A..Z) and the captured snapshot.
    int          pos = -1;
    logic        mDone = 1'b0;
    logic [11:0] mOff0 = 12'h000;
    logic [11:0] mOff1 = 12'h000;
    logic [7:0]  mEn   = 8'h00;

    function automatic logic [7:0] byteOf(input int idx);
        case (idx)
            0:       return mOff0[7:0];
            1:       return {mEn[3:0], mOff0[11:8]};
            2:       return mOff1[7:0];
            3:       return {mEn[7:4], mOff1[11:8]};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        mDone = 1'b0;
        if (reset) begin
            pos   = -1;
            mOff0 = 12'h000;
            mOff1 = 12'h000;
            mEn   = 8'h00;
        end else if (pos < 0) begin
            if (start && ready && !abort) begin
                pos   = 0;
                mOff0 = mapOffset0;
                mOff1 = mapOffset1;
                mEn   = mapEnable;
            end
        end else if (abort) begin
            pos = -1;
        end else if (ready) begin
            if (pos == 3) begin
                pos   = -1;
                mDone = 1'b1;
            end else begin
                pos = pos + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model.data",    dataOut, (pos < 0) ? 8'h00 : byteOf(pos));
            checkOutput("model.valid",   {7'd0, valid},   {7'd0, pos >= 0});
            checkOutput("model.busy",    {7'd0, busy},    {7'd0, pos >= 0});
            checkOutput("model.byteSel", {6'd0, byteSel}, (pos < 0) ? 8'd0 : 8'(pos));
            checkOutput("model.last",    {7'd0, last},    {7'd0, pos == 3});
            checkOutput("model.done",    {7'd0, done},    {7'd0, mDone});
        end
    end

    task automatic applyStimulus(input logic r, input logic rd, input logic s, input logic a);
        reset = r;
        ready = rd;
        start = s;
        abort = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ready = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mapOffset0 = 12'h000;
        mapOffset1 = 12'h000;
        mapEnable  = 8'h00;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkEn = 1;
        checkOutput("reset.data", dataOut, 8'h00);
        checkOutput("reset.busy", {7'd0, busy}, 8'h00);
        checkOutput("reset.done", {7'd0, done}, 8'h00);

        $display("[TB] basic playback, ready high");
        mapOffset0 = 12'h3A5;
        mapOffset1 = 12'hC07;
        mapEnable  = 8'hB6;
        applyStimulus(0, 1, 1, 0);
        checkOutput("t1.A", dataOut, 8'hA5);
        checkOutput("t1.lastA", {7'd0, last}, 8'h00);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t1.X", dataOut, 8'h63);
        checkOutput("t1.selX", {6'd0, byteSel}, 8'd1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t1.Y", dataOut, 8'h07);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t1.Z", dataOut, 8'hBC);
        checkOutput("t1.lastZ", {7'd0, last}, 8'h01);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t1.done", {7'd0, done}, 8'h01);
        checkOutput("t1.busyOff", {7'd0, busy}, 8'h00);
        checkOutput("t1.dataIdle", dataOut, 8'h00);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t1.donePulse", {7'd0, done}, 8'h00);

        $display("[TB] ready stall on X");
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t2.X1", dataOut, 8'h63);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2.X2", dataOut, 8'h63);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2.X3", dataOut, 8'h63);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2.X4", dataOut, 8'h63);
        checkOutput("t2.selX4", {6'd0, byteSel}, 8'd1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t2.Y", dataOut, 8'h07);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t2.Z", dataOut, 8'hBC);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t2.done", {7'd0, done}, 8'h01);

        $display("[TB] back-to-back start, live inputs changed");
        applyStimulus(0, 1, 1, 0);
        checkOutput("t3.A", dataOut, 8'hA5);
        mapOffset0 = 12'hFFF;
        mapOffset1 = 12'hFFF;
        mapEnable  = 8'hFF;
        applyStimulus(0, 1, 0, 0);
        checkOutput("t3.X", dataOut, 8'h63);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t3.Y", dataOut, 8'h07);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t3.Z", dataOut, 8'hBC);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t3.done", {7'd0, done}, 8'h01);

        $display("[TB] abort on Y, then fresh snapshot");
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t4.Y", dataOut, 8'hFF);
        applyStimulus(0, 1, 0, 1);
        checkOutput("t4.abortData", dataOut, 8'h00);
        checkOutput("t4.abortBusy", {7'd0, busy}, 8'h00);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t4.noDone", {7'd0, done}, 8'h00);
        mapOffset0 = 12'h123;
        mapOffset1 = 12'h456;
        mapEnable  = 8'h9C;
        applyStimulus(0, 1, 1, 0);
        checkOutput("t4.A", dataOut, 8'h23);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t4.X", dataOut, 8'hC1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t4.Y2", dataOut, 8'h56);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t4.Z", dataOut, 8'h94);
        applyStimulus(0, 1, 0, 0);

        $display("[TB] start while busy, start with abort in idle");
        applyStimulus(0, 1, 1, 0);
        mapOffset0 = 12'h3A5;
        mapOffset1 = 12'hC07;
        mapEnable  = 8'hB6;
        applyStimulus(0, 1, 0, 0);
        checkOutput("t5.X", dataOut, 8'hC1);
        applyStimulus(0, 1, 1, 0);
        checkOutput("t5.Y", dataOut, 8'h56);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t5.Z", dataOut, 8'h94);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t5.done", {7'd0, done}, 8'h01);
        applyStimulus(0, 1, 1, 1);
        checkOutput("t5.abortWins", {7'd0, busy}, 8'h00);
        applyStimulus(0, 1, 0, 0);

        $display("[TB] abort with ready on Z");
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t5b.Z", dataOut, 8'hBC);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t5b.noDone", {7'd0, done}, 8'h00);

        $display("[TB] reset during Z");
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t6.Z", dataOut, 8'hBC);
        applyStimulus(1, 1, 0, 0);
        checkOutput("t6.data", dataOut, 8'h00);
        checkOutput("t6.valid", {7'd0, valid}, 8'h00);
        checkOutput("t6.sel", {6'd0, byteSel}, 8'd0);
        checkOutput("t6.last", {7'd0, last}, 8'h00);
        checkOutput("t6.done", {7'd0, done}, 8'h00);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t6.noDone", {7'd0, done}, 8'h00);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
